// File: rtl/wb_pkg.sv
// Wishbone B4 cycle/burst encodings and slave state, shared by slaves and the burst master.
package wb_pkg;
    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CLASSIC = 2'b01,
        ST_BURST   = 2'b10
    } slave_state_t;
endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next beat address for linear and wrapping Wishbone bursts.
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            bte,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Bits inside wrap_mask come from the incremented address, the rest are held.
    always_comb begin
        inc = addr + ADDR_WIDTH'(1);
        case (bte)
            BTE_WRAP4:  wrap_mask = ADDR_WIDTH'(3);
            BTE_WRAP8:  wrap_mask = ADDR_WIDTH'(7);
            BTE_WRAP16: wrap_mask = ADDR_WIDTH'(15);
            default:    wrap_mask = '1;
        endcase
        next_addr = (addr & ~wrap_mask) | (inc & wrap_mask);
    end
endmodule

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B4 slave memory with classic cycles and registered-feedback incrementing bursts.
// state      | meaning
// ST_IDLE    | waiting for cyc_i & stb_i
// ST_CLASSIC | single response cycle (classic beat or last burst beat); bus not sampled
// ST_BURST   | burst open; each strobed edge is a beat at the internal counter
module wb_burst_slave_mem
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [2:0]            cti_i,
    input  logic [1:0]            bte_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o
);
    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    slave_state_t          state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [IDX_W-1:0]      idx;
    logic                  beat;
    logic                  in_range;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign beat      = cyc_i & stb_i & (state != ST_CLASSIC);
    assign beat_addr = (state == ST_BURST) ? cnt : adr_i;
    assign idx       = beat_addr[IDX_W-1:0];
    assign in_range  = {1'b0, beat_addr} < DEPTH_L;
    // Outside a burst only CTI_INCR opens one; inside, classic or end-of-burst closes it.
    assign last_beat = (state == ST_BURST) ? ((cti_i == CTI_EOB) || (cti_i == CTI_CLASSIC))
                                           : (cti_i != CTI_INCR);

    wb_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (beat_addr),
        .bte       (bte_i),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            busy_o <= 1'b0;
            dat_o  <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;

            case (state)
                ST_IDLE: begin
                    if (beat) begin
                        state  <= last_beat ? ST_CLASSIC : ST_BURST;
                        cnt    <= next_addr;
                        busy_o <= 1'b1;
                    end
                end
                ST_CLASSIC: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                ST_BURST: begin
                    if (!cyc_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (stb_i) begin
                        cnt <= next_addr;
                        if (last_beat) state <= ST_CLASSIC;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            // A beat never issues when cyc_i is low, so an abort gives no response.
            if (beat) begin
                if (in_range) begin
                    ack_o <= 1'b1;
                    if (we_i) begin
                        for (int b = 0; b < SEL_WIDTH; b++) begin
                            if (sel_i[b]) mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
                        end
                    end else begin
                        dat_o <= mem[idx];
                    end
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Randomised and directed bench for wb_burst_slave_mem against a cycle-level reference model.
module tb_wb_burst_slave_mem;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i  = 1'b0;
    logic [AW-1:0] adr_i = '0;
    logic [DW-1:0] dat_i = '0;
    logic [SW-1:0] sel_i = '0;
    logic [2:0]    cti_i = '0;
    logic [1:0]    bte_i = '0;
    logic [DW-1:0] dat_o;
    logic          ack_o;
    logic          err_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    wb_burst_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .cti_i(cti_i), .bte_i(bte_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Burst address sequence from arithmetic: wrap keeps the aligned N-word block.
    function automatic int nxt(input int a, input int bte);
        int n;
        if (bte == 0) return (a + 1) % 16;
        n = 4 << (bte - 1);
        return (a - a % n) + (a + 1) % n;
    endfunction

    logic [DW-1:0] mem_m [DEPTH];
    bit            in_burst = 0;
    bit            blind    = 0;
    int            baddr    = 0;
    bit            exp_ack  = 0;
    bit            exp_err  = 0;
    bit            exp_busy = 0;
    bit            exp_rd   = 0;
    logic [DW-1:0] exp_dat  = '0;

    always @(posedge clk_i or negedge rst_i) begin : model
        int a;
        bit fin;
        if (!rst_i) begin
            in_burst = 0; blind = 0;
            exp_ack = 0; exp_err = 0; exp_rd = 0; exp_busy = 0;
        end else begin
            exp_ack = 0; exp_err = 0; exp_rd = 0;
            if (blind) begin
                blind = 0;
            end else if (in_burst && !cyc_i) begin
                in_burst = 0;
            end else if (cyc_i && stb_i) begin
                a = in_burst ? baddr : int'(adr_i);
                if (a < DEPTH) begin
                    exp_ack = 1;
                    if (we_i) begin
                        for (int b = 0; b < SW; b++)
                            if (sel_i[b]) mem_m[a[2:0]][8*b +: 8] = dat_i[8*b +: 8];
                    end else begin
                        exp_rd  = 1;
                        exp_dat = mem_m[a[2:0]];
                    end
                end else begin
                    exp_err = 1;
                end
                fin = in_burst ? (cti_i == 3'b111 || cti_i == 3'b000) : (cti_i != 3'b010);
                if (fin) begin
                    in_burst = 0; blind = 1;
                end else begin
                    in_burst = 1; baddr = nxt(a, int'(bte_i));
                end
            end
            exp_busy = in_burst || blind;
        end
    end

    always @(negedge clk_i) begin
        chk("ack", {31'b0, ack_o}, {31'b0, exp_ack});
        chk("err", {31'b0, err_o}, {31'b0, exp_err});
        chk("busy", {31'b0, busy_o}, {31'b0, exp_busy});
        if (exp_rd)  chk("rdata", dat_o, exp_dat);
        if (exp_err) chk("err_dat", dat_o, 32'h0);
    end

    logic          r_ack, r_err, r_ack2;
    logic [DW-1:0] r_dat;

    // Called and returns on a falling edge; outputs of the sampled beat are visible on return.
    task automatic drive(input bit c, input bit s, input bit w, input int a, input logic [31:0] d,
                         input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
        cyc_i = c; stb_i = s; we_i = w; adr_i = AW'(a); dat_i = d; sel_i = sl; cti_i = ct; bte_i = bt;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Request edge, then a response edge with the strobe still held.
    task automatic classic(input bit w, input int a, input logic [31:0] d, input logic [3:0] sl);
        drive(1'b1, 1'b1, w, a, d, sl, 3'b000, 2'b00);
        r_ack = ack_o; r_err = err_o; r_dat = dat_o;
        drive(1'b1, 1'b1, w, a, d, sl, 3'b000, 2'b00);
        r_ack2 = ack_o;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    initial begin
        bit          c, s, w;
        int          a;
        logic [31:0] d;
        logic [3:0]  sl;
        logic [2:0]  ct;
        logic [1:0]  bt;

        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        rst_i = 1'b1;

        for (int i = 0; i < DEPTH; i++) classic(1'b1, i, 32'(i), 4'hF);

        classic(1'b1, 0, 32'h0000_1111, 4'hF);
        classic(1'b0, 0, 32'h0, 4'hF);
        chk("rd0_ack", {31'b0, r_ack}, 32'h1);
        chk("rd0_dat", r_dat, 32'h0000_1111);
        chk("rd0_ack_low", {31'b0, r_ack2}, 32'h0);

        classic(1'b1, 1, 32'hAABB_CCDD, 4'hF);
        classic(1'b1, 1, 32'h1122_3344, 4'b0101);
        classic(1'b0, 1, 32'h0, 4'hF);
        chk("bytesel", r_dat, 32'hAA22_CC44);

        classic(1'b1, 9, 32'h0000_2222, 4'hF);
        chk("oor_err", {31'b0, r_err}, 32'h1);
        chk("oor_ack", {31'b0, r_ack}, 32'h0);
        classic(1'b0, 1, 32'h0, 4'hF);
        chk("oor_keep", r_dat, 32'hAA22_CC44);
        idle();

        // Linear read burst from 4; adr_i after the first beat is junk and must be ignored.
        drive(1'b1, 1'b1, 1'b0, 4, 32'h0, 4'hF, 3'b010, 2'b00);
        chk("lin_b0", dat_o, 32'd4);
        drive(1'b1, 1'b1, 1'b0, 15, 32'h0, 4'hF, 3'b010, 2'b00);
        chk("lin_b1", dat_o, 32'd5);
        drive(1'b1, 1'b1, 1'b0, 15, 32'h0, 4'hF, 3'b010, 2'b00);
        chk("lin_b2", dat_o, 32'd6);
        drive(1'b1, 1'b1, 1'b0, 15, 32'h0, 4'hF, 3'b111, 2'b00);
        chk("lin_b3", dat_o, 32'd7);
        chk("lin_b3_ack", {31'b0, ack_o}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 15, 32'h0, 4'hF, 3'b111, 2'b00);
        chk("lin_end_busy", {31'b0, busy_o}, 32'h0);
        chk("lin_end_ack", {31'b0, ack_o}, 32'h0);
        idle();

        // Wrap4 read burst from 6 with a wait state after beat 2.
        drive(1'b1, 1'b1, 1'b0, 6, 32'h0, 4'hF, 3'b010, 2'b01);
        chk("wr4_b0", dat_o, 32'd6);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b01);
        chk("wr4_b1", dat_o, 32'd7);
        drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b01);
        chk("wr4_wait_ack", {31'b0, ack_o}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b01);
        chk("wr4_b2", dat_o, 32'd4);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b111, 2'b01);
        chk("wr4_b3", dat_o, 32'd5);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b111, 2'b01);
        chk("wr4_end_busy", {31'b0, busy_o}, 32'h0);
        idle();

        // Abort: drop cyc_i mid-burst.
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b00);
        chk("abort_pre", dat_o, 32'hAA22_CC44);
        drive(1'b0, 1'b1, 1'b0, 0, 32'h0, 4'hF, 3'b010, 2'b00);
        chk("abort_ack", {31'b0, ack_o}, 32'h0);
        chk("abort_busy", {31'b0, busy_o}, 32'h0);
        idle();
        chk("abort_ack2", {31'b0, ack_o}, 32'h0);

        // Reset while the second write beat of a burst is on the bus.
        drive(1'b1, 1'b1, 1'b1, 2, 32'h5555_0002, 4'hF, 3'b010, 2'b00);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 32'hDEAD_BEEF; cti_i = 3'b010;
        #2 rst_i = 1'b0;
        #1;
        chk("rst_mid_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_mid_err", {31'b0, err_o}, 32'h0);
        chk("rst_mid_busy", {31'b0, busy_o}, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0;
        rst_i = 1'b1;
        classic(1'b0, 3, 32'h0, 4'hF);
        chk("rst_mid_keep", r_dat, 32'd3);
        classic(1'b0, 2, 32'h0, 4'hF);
        chk("rst_mid_prev", r_dat, 32'h5555_0002);

        for (int k = 0; k < 500; k++) begin
            c  = ($urandom_range(0, 11) != 0);
            s  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 11));
            d  = $urandom;
            sl = 4'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1:    ct = 3'b000;
                2, 3:    ct = 3'b111;
                4:       ct = 3'b011;
                default: ct = 3'b010;
            endcase
            drive(c, s, w, a, d, sl, ct, bt);
        end
        idle();
        idle();

        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_burst_slave_mem.md
Name: wb_burst_slave_mem

Overview:
- Wishbone B4 slave memory that sits directly downstream of the interconnect in the multi-slave system.
- Connects to one stb lane; a second instance serves the other lane.
- Serves classic single read/write cycles and registered-feedback incrementing bursts (CTI/BTE).
- Byte-lane writes via sel_i; err_o on out-of-range addresses.

Parameters:
ADDR_WIDTH, 4, word address width of adr_i
DATA_WIDTH, 32, data bus width (multiple of 8)
SEL_WIDTH, DATA_WIDTH/8, byte-select width
DEPTH, 8, implemented words; valid addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe (this slave's lane)
we_i  in  1  1 = write, 0 = read
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data
sel_i  in  SEL_WIDTH  byte enables
cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
dat_o  out  DATA_WIDTH  read data, valid while ack_o = 1
ack_o  out  1  normal termination
err_o  out  1  error termination
busy_o  out  1  high while state != IDLE

Behaviour:
- Reset (rst_i = 0, async):
  - state = IDLE; ack_o, err_o, busy_o = 0; dat_o = 0; burst counter = 0.
  - Memory contents are not cleared.
- Request: a request is sampled at a rising edge when cyc_i & stb_i = 1.
- Address check: any beat whose address is >= DEPTH terminates with err_o instead of ack_o.
  - An errored beat performs no write; dat_o = 0.
- ack_o and err_o are mutually exclusive and never high together.
- Writes: byte lane b is updated only when sel_i[b] = 1 and the beat is acked.
- Reads: dat_o = mem[addr] of the beat, registered, presented in the ack cycle.
- State machine:
  - IDLE: on a request with cti_i = 000, 111, or reserved 011-110 -> CLASSIC. On a request with cti_i = 010 -> BURST.
  - In both cases the response (ack_o or err_o) is asserted for exactly one cycle after the sampling edge (latency 1).
  - The burst counter loads next(adr_i).
  - CLASSIC: response cycle; ack_o/err_o = 1. Next edge -> IDLE unconditionally, so a held stb_i is never re-sampled in the response cycle. Classic throughput is one transfer per 2 cycles.
  - BURST:
    - Each edge with cyc_i & stb_i = 1 issues a beat; the response appears in the following cycle. Back-to-back beats give ack every cycle.
    - Beat address is the internal counter; adr_i is ignored after the first beat.
    - Counter advances per beat using next().
    - stb_i = 0 (wait state): no response next cycle, counter held, state held.
    - A beat sampled with cti_i = 111 is the final beat: it is acked, then -> IDLE.
    - cti_i = 000 mid-burst is treated as final.
    - cyc_i = 0 at any edge -> IDLE immediately with no response; the cycle is aborted.
- Counter next():
  - Linear: addr+1 modulo 2**ADDR_WIDTH. Overflow past DEPTH-1 yields err beats.
  - Wrapping (N = 4/8/16): low log2(N) bits increment modulo N; upper bits held.
- we_i is sampled per beat; a mix of read and write beats within one burst is allowed.
- Reset mid-burst: immediate IDLE, outputs cleared, any in-flight write not committed.

Decomposition:
- Package wb_pkg:
  - cti_t enum (CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111)
  - bte_t enum (BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16)
  - slave state enum (ST_IDLE, ST_CLASSIC, ST_BURST)
- Sub-module wb_burst_addr_gen: combinational next-address from (addr, bte), parameterised by ADDR_WIDTH. Shared with the future burst master.

Test Plan:
- Classic write then read: write adr 0 = 32'h0000_1111, sel = 4'hF; read adr 0 -> ack_o one cycle after strobe, dat_o = 32'h0000_1111, ack_o low the following cycle.
- Byte-select: write adr 1 = 32'hAABB_CCDD sel = 4'hF, then 32'h1122_3344 sel = 4'b0101; read adr 1 -> 32'hAA22_CC44.
- Out-of-range: write adr 9 = 32'h0000_2222 (DEPTH = 8) -> err_o = 1, ack_o = 0 for one cycle; adr 1 unchanged.
- Linear burst: cti 010, 010, 010, 111 from adr 4, reads after prefilling mem[i] = i -> acks on 4 consecutive cycles, dat_o = 4, 5, 6, 7, then busy_o = 0.
- Wrap4 burst: from adr 6, 4 beats with a wait state (stb_i = 0) inserted after beat 2 -> addresses 6, 7, 4, 5; no ack in the wait cycle; counter held.
- Abort and reset: drop cyc_i mid-burst -> IDLE with no further ack. Assert rst_i = 0 mid-write -> ack_o, err_o, busy_o = 0 immediately, target word unchanged.
